// File: rtl/partition_sweep_pkg.sv
// rtl/partition_sweep_pkg.sv - shared state type and width helpers for the partition sweep controller
package partition_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        EMIT,
        DONE
    } sweep_state_e;

    // Widths for the default 7-in/4-out partition; modules derive their own from parameters.
    localparam int NUM_IN_DEF  = 7;
    localparam int NUM_OUT_DEF = 4;
    localparam int CNT_W       = NUM_IN_DEF + 1;
    localparam int HD_W        = $clog2(NUM_OUT_DEF + 1);
    localparam int HDSUM_W     = NUM_IN_DEF + HD_W;

    function automatic int hd_width(input int num_out);
        return $clog2(num_out + 1);
    endfunction

endpackage

// File: rtl/popcount_xor.sv
// rtl/popcount_xor.sv - Hamming distance between two words (XOR then population count)
module popcount_xor #(
    parameter int NUM_OUT = 4,
    parameter int HD_W    = $clog2(NUM_OUT + 1)
) (
    input  logic [NUM_OUT-1:0] a_i,
    input  logic [NUM_OUT-1:0] b_i,
    output logic [HD_W-1:0]    hd_o
);

    logic [NUM_OUT-1:0] diff;

    always_comb begin
        diff = a_i ^ b_i;
        hd_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            hd_o = hd_o + HD_W'(diff[i]);
        end
    end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// rtl/partition_sweep_ctrl.sv - exhaustive truth-table sweep of exact vs approximate partition with error metrics
module partition_sweep_ctrl
    import partition_sweep_pkg::*;
#(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int SETTLE  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      abort,
    output logic [NUM_IN-1:0]                         pi_o,
    input  logic [NUM_OUT-1:0]                        po_exact_i,
    input  logic [NUM_OUT-1:0]                        po_approx_i,
    output logic                                      rec_valid,
    input  logic                                      rec_ready,
    output logic [NUM_IN-1:0]                         rec_pattern,
    output logic [NUM_OUT-1:0]                        rec_po,
    output logic                                      rec_mismatch,
    output logic                                      busy,
    output logic                                      done,
    output logic [NUM_IN:0]                           err_count,
    output logic [NUM_IN+$clog2(NUM_OUT+1)-1:0]       hd_sum,
    output logic [$clog2(NUM_OUT+1)-1:0]              max_hd
);

    localparam int L_CNT_W   = NUM_IN + 1;
    localparam int L_HD_W    = hd_width(NUM_OUT);
    localparam int L_HDSUM_W = NUM_IN + L_HD_W;
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    sweep_state_e           state_q;
    logic [NUM_IN-1:0]      pi_q;
    logic [3:0]             settle_q;
    logic                   rec_valid_q;
    logic [NUM_IN-1:0]      rec_pattern_q;
    logic [NUM_OUT-1:0]     rec_po_q;
    logic                   rec_mis_q;
    logic                   busy_q;
    logic                   done_q;
    logic [L_CNT_W-1:0]     err_q;
    logic [L_HDSUM_W-1:0]   hd_sum_q;
    logic [L_HD_W-1:0]      max_hd_q;
    logic [L_HD_W-1:0]      hd_d;

    popcount_xor #(
        .NUM_OUT (NUM_OUT),
        .HD_W    (L_HD_W)
    ) u_popcount_xor (
        .a_i  (po_exact_i),
        .b_i  (po_approx_i),
        .hd_o (hd_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pi_q          <= '0;
            settle_q      <= '0;
            rec_valid_q   <= 1'b0;
            rec_pattern_q <= '0;
            rec_po_q      <= '0;
            rec_mis_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= '0;
            hd_sum_q      <= '0;
            max_hd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q    <= '0;
                        hd_sum_q <= '0;
                        max_hd_q <= '0;
                        pi_q     <= '0;
                        settle_q <= SETTLE_L;
                        busy_q   <= 1'b1;
                        state_q  <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pi_q    <= '0;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                        if (settle_q == 4'd1) begin
                            state_q <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pi_q    <= '0;
                    end else begin
                        err_q    <= err_q + L_CNT_W'(hd_d != '0);
                        hd_sum_q <= hd_sum_q + L_HDSUM_W'(hd_d);
                        if (hd_d > max_hd_q) begin
                            max_hd_q <= hd_d;
                        end
                        rec_pattern_q <= pi_q;
                        rec_po_q      <= po_approx_i;
                        rec_mis_q     <= (po_approx_i != po_exact_i);
                        rec_valid_q   <= 1'b1;
                        state_q       <= EMIT;
                    end
                end
                EMIT: begin
                    // Abort beats a coincident handshake; that record is treated as consumed.
                    if (abort) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        rec_valid_q <= 1'b0;
                        pi_q        <= '0;
                    end else if (rec_ready) begin
                        rec_valid_q <= 1'b0;
                        if (pi_q == '1) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pi_q    <= '0;
                        end else begin
                            pi_q     <= pi_q + NUM_IN'(1);
                            settle_q <= SETTLE_L;
                            state_q  <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pi_o         = pi_q;
    assign rec_valid    = rec_valid_q;
    assign rec_pattern  = rec_pattern_q;
    assign rec_po       = rec_po_q;
    assign rec_mismatch = rec_mis_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_q;
    assign hd_sum       = hd_sum_q;
    assign max_hd       = max_hd_q;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// tb/tb_partition_sweep_ctrl.sv - scoreboard bench for partition_sweep_ctrl
module tb_partition_sweep_ctrl;

    localparam int NI = 7;
    localparam int NO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rec_ready = 1'b1;
    logic [NI-1:0] pi_o;
    logic [NO-1:0] po_exact, po_approx;
    logic          rec_valid, rec_mismatch, busy, done;
    logic [NI-1:0] rec_pattern;
    logic [NO-1:0] rec_po;
    logic [NI:0]   err_count;
    logic [NI+2:0] hd_sum;
    logic [2:0]    max_hd;

    int  mode = 0;
    bit  rdy_rand = 1'b0;
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  n_done = 0;

    typedef struct packed {
        logic [NI-1:0] pat;
        logic [NO-1:0] po;
        logic          mis;
    } rec_t;
    rec_t exp_q[$];

    partition_sweep_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pi_o         (pi_o),
        .po_exact_i   (po_exact),
        .po_approx_i  (po_approx),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_pattern  (rec_pattern),
        .rec_po       (rec_po),
        .rec_mismatch (rec_mismatch),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .hd_sum       (hd_sum),
        .max_hd       (max_hd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Partition models: mode 0 identical, mode 1 flips bits 0 and 2, mode 2 drops bit 0.
    always_comb begin
        po_exact  = pi_o[3:0];
        po_approx = pi_o[3:0];
        if (mode == 1)
            po_approx = pi_o[3:0] ^ 4'b0101;
        else if (mode == 2)
            po_approx = pi_o[3:0] & 4'b1110;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rec_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic rec_t exp_rec(input int pat, input int m);
        rec_t r;
        logic [NI-1:0] p;
        p = NI'(pat);
        r.pat = p;
        r.po = (m == 1) ? (p[3:0] ^ 4'b0101) : (m == 2) ? (p[3:0] & 4'b1110) : p[3:0];
        r.mis = (r.po != p[3:0]);
        return r;
    endfunction

    task automatic push_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) exp_q.push_back(exp_rec(p, mode));
    endtask

    // Monitor: pop on every handshake, and hold-stability while stalled.
    bit            stall_prev = 1'b0;
    logic [NI-1:0] s_pi, s_pat;
    logic [NO-1:0] s_po;
    logic          s_mis;
    always @(negedge clk) begin
        rec_t e;
        if (done) n_done++;
        if (stall_prev && !rst && !abort) begin
            check("hold_valid", rec_valid, 1);
            check("hold_pi", pi_o, s_pi);
            check("hold_pattern", rec_pattern, s_pat);
            check("hold_po", rec_po, s_po);
            check("hold_mismatch", rec_mismatch, s_mis);
        end
        if (rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", rec_pattern, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("rec_pattern", rec_pattern, e.pat);
                check("rec_po", rec_po, e.po);
                check("rec_mismatch", rec_mismatch, e.mis);
            end
        end
        stall_prev = rec_valid && !rec_ready && !rst && !abort;
        s_pi = pi_o; s_pat = rec_pattern; s_po = rec_po; s_mis = rec_mismatch;
    end

    task automatic pulse_start(output int s_cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input int bound, input bit busy_start, output bit found, output int at);
        found = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            start = (busy_start && i == 100);
            if (done) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", found, 1);
    endtask

    task automatic check_metrics(input string tag, input int e, input int h, input int m);
        check({tag, "_err_count"}, err_count, e);
        check({tag, "_hd_sum"}, hd_sum, h);
        check({tag, "_max_hd"}, max_hd, m);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic full_sweep(input int m, input bit rr, input bit timed, input bit busy_start,
                              input int e, input int h, input int mh, input string tag);
        int  s_cyc, at;
        bit  found;
        mode = m;
        rdy_rand = rr;
        push_range(0, 127);
        pulse_start(s_cyc);
        check({tag, "_cleared_err"}, err_count, 0);
        check({tag, "_busy"}, busy, 1);
        wait_done(6000, busy_start, found, at);
        if (timed) check({tag, "_done_cycle"}, at - s_cyc + 1, 385);
        check({tag, "_busy_in_done"}, busy, 0);
        check_metrics(tag, e, h, mh);
        rdy_rand = 1'b0;
    endtask

    initial begin
        int  s_cyc, nd;
        repeat (3) @(negedge clk);
        check("reset_pi", pi_o, 0);
        check("reset_valid", rec_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_metrics", {err_count, hd_sum, max_hd}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        full_sweep(0, 1'b0, 1'b1, 1'b1, 0, 0, 0, "exact");
        // start presented while in DONE must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_width", done, 0);
        nd = n_done;
        repeat (4) @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        check("no_extra_done", n_done, nd);

        full_sweep(1, 1'b0, 1'b1, 1'b0, 128, 256, 2, "xor0101");
        full_sweep(2, 1'b0, 1'b1, 1'b0, 64, 64, 1, "drop_bit0");
        full_sweep(2, 1'b1, 1'b0, 1'b0, 64, 64, 1, "backpressure");

        // abort while pattern 50 is being applied
        mode = 2;
        push_range(0, 49);
        pulse_start(s_cyc);
        for (int i = 0; i < 1000 && !(busy && pi_o == 7'd50); i++) @(negedge clk);
        check("abort_reached_50", pi_o, 50);
        nd = n_done;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", rec_valid, 0);
        check("abort_pi", pi_o, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", n_done, nd);
        check_metrics("abort", 25, 25, 1);
        full_sweep(2, 1'b0, 1'b1, 1'b0, 64, 64, 1, "after_abort");

        // reset while record 20 is on offer
        mode = 1;
        push_range(0, 20);
        pulse_start(s_cyc);
        for (int i = 0; i < 1000 && !(rec_valid && rec_pattern == 7'd20); i++) @(negedge clk);
        check("rst_reached_20", rec_pattern, 20);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pi", pi_o, 0);
        check("rst_rec", {rec_valid, rec_pattern, rec_po, rec_mismatch}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_metrics", {err_count, hd_sum, max_hd}, 0);
        check("rst_queue_empty", exp_q.size(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
